// File: rtl/lcd_cmd_arbiter_if.sv
// Purpose : request/grant and LCD-controller signal bundle for lcd_cmd_arbiter.
// Latency : n/a (wires only).
// Backpressure: requesters hold iReqN/iCmdN until the one-cycle oGntN pulse.
// Ports   : slave  = arbiter side (takes requests and iLCD_Done, drives grants/LCD/status)
//           master = environment side (requesters plus LCD controller)
interface lcd_cmd_arbiter_if;
  logic       iReq0;
  logic [8:0] iCmd0;
  logic       oGnt0;
  logic       iReq1;
  logic [8:0] iCmd1;
  logic       oGnt1;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_Start;
  logic       iLCD_Done;
  logic       oBusy;
  logic       oOwner;
  logic       oErr;

  modport slave (
    input  iReq0, iCmd0, iReq1, iCmd1, iLCD_Done,
    output oGnt0, oGnt1, oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oOwner, oErr
  );

  modport master (
    output iReq0, iCmd0, iReq1, iCmd1, iLCD_Done,
    input  oGnt0, oGnt1, oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oOwner, oErr
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Purpose : round-robin arbiter feeding 9-bit {RS,data} commands from two requesters to one LCD controller.
// Latency : request seen in IDLE -> grant pulse and oLCD_Start one cycle later; DLY_MAX+1 settle cycles after done.
// Backpressure: grants only in IDLE; requesters hold iReqN until oGntN, LCD side holds Start until iLCD_Done or timeout.
// Ports   : iCLK, iRST (sync, active-high); bus (slave modport) carries iReq0/1, iCmd0/1, oGnt0/1,
//           oLCD_DATA, oLCD_RS, oLCD_Start, iLCD_Done, oBusy, oOwner, oErr.
module lcd_cmd_arbiter #(
  parameter int DLY_MAX = 262142,
  parameter int TIMEOUT = 1023
) (
  input logic              iCLK,
  input logic              iRST,
  lcd_cmd_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;

  // Last WAIT_DONE count value: Start stays high for exactly TIMEOUT cycles.
  localparam logic [9:0]  L_TO_LAST = 10'(TIMEOUT - 1);
  localparam logic [17:0] L_DLY_END = 18'(DLY_MAX);

  logic [1:0]  r_state;
  logic [9:0]  r_wcnt;
  logic [17:0] r_dcnt;
  logic        r_gnt0;
  logic        r_gnt1;
  logic [7:0]  r_data;
  logic        r_rs;
  logic        r_start;
  logic        r_busy;
  logic        r_owner;
  logic        r_err;

  logic        w_any;
  logic        w_pick1;
  logic [8:0]  w_cmd;

  // On a tie the requester that did not win last time goes next.
  assign w_any   = bus.iReq0 | bus.iReq1;
  assign w_pick1 = (bus.iReq0 & bus.iReq1) ? ~r_owner : bus.iReq1;
  assign w_cmd   = w_pick1 ? bus.iCmd1 : bus.iCmd0;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= 1'b1;  // makes requester 0 win the first tie
      r_err   <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_owner <= w_pick1;
            r_data  <= w_cmd[7:0];
            r_rs    <= w_cmd[8];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Done is checked first so a done on the timeout cycle leaves oErr alone.
          if (bus.iLCD_Done) begin
            r_start <= 1'b0;
            r_wcnt  <= '0;
            r_state <= S_DELAY;
          end else if (r_wcnt == L_TO_LAST) begin
            r_start <= 1'b0;
            r_err   <= 1'b1;
            r_wcnt  <= '0;
            r_state <= S_DELAY;
          end else begin
            r_wcnt <= r_wcnt + 10'd1;
          end
        end
        S_DELAY: begin
          if (r_dcnt == L_DLY_END) begin
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dcnt <= r_dcnt + 18'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_wcnt  <= '0;
          r_dcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.oGnt0      = r_gnt0;
  assign bus.oGnt1      = r_gnt1;
  assign bus.oLCD_DATA  = r_data;
  assign bus.oLCD_RS    = r_rs;
  assign bus.oLCD_Start = r_start;
  assign bus.oBusy      = r_busy;
  assign bus.oOwner     = r_owner;
  assign bus.oErr       = r_err;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Purpose : self-checking bench for lcd_cmd_arbiter (DLY_MAX=4, TIMEOUT=8) with a grant scoreboard.
// Latency : n/a.
// Backpressure: bench requesters hold requests until their grant is observed.
module tb_lcd_cmd_arbiter;

  typedef struct packed {
    logic       idx;
    logic [8:0] cmd;
  } exp_t;

  logic clk;
  logic rst;
  logic auto_done;
  logic man_done;
  int   n_chk;
  int   n_pass;
  int   n_gnt;
  exp_t sb_q[$];

  lcd_cmd_arbiter_if bus();

  lcd_cmd_arbiter #(.DLY_MAX(4), .TIMEOUT(8)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  // LCD controller model: either answers done as soon as it sees Start, or is driven by hand.
  assign bus.iLCD_Done = auto_done ? bus.oLCD_Start : man_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Grant monitor: every grant must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.oGnt0 || bus.oGnt1) begin
      n_gnt++;
      check("gnt_excl", 32'(bus.oGnt0 & bus.oGnt1), 32'd0);
      check("gnt_expected", 32'(bus.oGnt0 | bus.oGnt1), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("gnt_idx", 32'(bus.oGnt1), 32'(e.idx));
        check("gnt_rs", 32'(bus.oLCD_RS), 32'(e.cmd[8]));
        check("gnt_data", 32'(bus.oLCD_DATA), 32'(e.cmd[7:0]));
        check("gnt_owner", 32'(bus.oOwner), 32'(e.idx));
        check("gnt_start", 32'(bus.oLCD_Start), 32'd1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic push_exp(input logic idx, input logic [8:0] cmd);
    exp_t e;
    e.idx = idx;
    e.cmd = cmd;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise one request, wait for its grant, then drop it. n = negedges waited.
  task automatic issue(input logic idx, input logic [8:0] cmd, output int n);
    push_exp(idx, cmd);
    if (idx) begin bus.iCmd1 = cmd; bus.iReq1 = 1'b1; end
    else     begin bus.iCmd0 = cmd; bus.iReq0 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idx ? bus.oGnt1 : bus.oGnt0) && n < 40);
    check("gnt_seen", 32'(idx ? bus.oGnt1 : bus.oGnt0), 32'd1);
    bus.iReq0 = 1'b0;
    bus.iReq1 = 1'b0;
  endtask

  task automatic run_done(input int wait_n);
    repeat (wait_n) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.oBusy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_gnt0"},  32'(bus.oGnt0), 32'd0);
    check({pfx, "_gnt1"},  32'(bus.oGnt1), 32'd0);
    check({pfx, "_start"}, 32'(bus.oLCD_Start), 32'd0);
    check({pfx, "_busy"},  32'(bus.oBusy), 32'd0);
    check({pfx, "_err"},   32'(bus.oErr), 32'd0);
    check({pfx, "_data"},  32'(bus.oLCD_DATA), 32'd0);
    check({pfx, "_rs"},    32'(bus.oLCD_RS), 32'd0);
    check({pfx, "_owner"}, 32'(bus.oOwner), 32'd1);
  endtask

  initial begin
    int n;
    int g0;
    logic prev_busy;
    n_chk = 0; n_pass = 0; n_gnt = 0;
    rst = 1'b1; auto_done = 1'b0; man_done = 1'b0;
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0; bus.iCmd0 = '0; bus.iCmd1 = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single command with done three cycles after the grant.
    issue(1'b0, 9'h138, n);
    check("gnt_latency", 32'(n), 32'd1);
    @(negedge clk);
    check("gnt_pulse", 32'(bus.oGnt0), 32'd0);
    check("start_held", 32'(bus.oLCD_Start), 32'd1);
    check("busy_wait", 32'(bus.oBusy), 32'd1);
    run_done(2);
    check("start_fall", 32'(bus.oLCD_Start), 32'd0);
    wait_idle(n);
    check("dly_cycles", 32'(n), 32'd5);
    check("data_hold", 32'(bus.oLCD_DATA), 32'h38);
    check("rs_hold", 32'(bus.oLCD_RS), 32'd1);
    check("err_clean", 32'(bus.oErr), 32'd0);

    // Both requests held: grants alternate starting with requester 0.
    do_reset();
    push_exp(1'b0, 9'h0A1); push_exp(1'b1, 9'h1B2);
    push_exp(1'b0, 9'h0A1); push_exp(1'b1, 9'h1B2);
    g0 = n_gnt;
    bus.iCmd0 = 9'h0A1; bus.iCmd1 = 9'h1B2;
    auto_done = 1'b1;
    bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
    n = 0;
    while (n_gnt - g0 < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    wait_idle(n);
    auto_done = 1'b0;
    check("alt_count", 32'(n_gnt - g0), 32'd4);
    check("alt_drained", 32'(sb_q.size()), 32'd0);

    // Requester 1 arrives during requester 0's settle delay.
    do_reset();
    issue(1'b0, 9'h0C3, n);
    run_done(1);
    check("in_delay", 32'(bus.oBusy & ~bus.oLCD_Start), 32'd1);
    push_exp(1'b1, 9'h1E4);
    bus.iCmd1 = 9'h1E4; bus.iReq1 = 1'b1;
    prev_busy = 1'b1;
    n = 0;
    while (!bus.oGnt1 && n < 30) begin
      prev_busy = bus.oBusy;
      @(negedge clk);
      n++;
    end
    check("late_gnt1", 32'(bus.oGnt1), 32'd1);
    check("late_after_idle", 32'(prev_busy), 32'd0);
    bus.iReq1 = 1'b0;
    run_done(2);
    wait_idle(n);

    // Done withheld: timeout after 8 Start cycles, oErr sticks.
    issue(1'b0, 9'h055, n);
    n = 0;
    while (bus.oLCD_Start && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("to_start_cycles", 32'(n), 32'd8);
    check("to_err", 32'(bus.oErr), 32'd1);
    wait_idle(n);
    issue(1'b1, 9'h1AA, n);
    run_done(1);
    wait_idle(n);
    check("err_sticky", 32'(bus.oErr), 32'd1);

    // Done on the timeout cycle wins.
    do_reset();
    check("err_cleared", 32'(bus.oErr), 32'd0);
    issue(1'b0, 9'h077, n);
    repeat (7) @(negedge clk);
    check("start_pre_to", 32'(bus.oLCD_Start), 32'd1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("to_done_start", 32'(bus.oLCD_Start), 32'd0);
    check("to_done_err", 32'(bus.oErr), 32'd0);
    wait_idle(n);

    // Reset during WAIT_DONE, then a tie goes to requester 0.
    issue(1'b0, 9'h1F0, n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    push_exp(1'b0, 9'h012);
    bus.iCmd0 = 9'h012; bus.iCmd1 = 9'h134;
    bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.oGnt0 || bus.oGnt1) && n < 20);
    check("tie_gnt0", 32'(bus.oGnt0), 32'd1);
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    run_done(1);
    wait_idle(n);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
